mac_rx: RTL and testbench
=========================

# mac_rx

RMII receive MAC for the switch fabric. It samples `crs_dv`/`rx_data` dibits at 50 MHz (100 Mb/s) and detects preamble plus SFD. It then assembles payload dibits LSB-first into bytes and emits a byte stream with start/end-of-frame markers, error flag and frame length. It is the receive-side counterpart of the blasting TX MAC and feeds the switch's ingress buffer.

## Interface
- `MAX_FRAME_BYTES`, default 1518: maximum payload bytes after SFD (DA through FCS); longer frames are truncated and flagged.
- `MIN_PREAMBLE_DIBITS`, default 8: minimum count of `01` dibits required before the SFD `11` dibit.
- `LEN_W`, default `$clog2(MAX_FRAME_BYTES+1)`: width of the length output.

Ports:
- `clk`  in  1  50 MHz RMII reference clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `crs_dv`  in  1  RMII carrier sense / data valid.
- `rx_data`  in  2  RMII receive dibit.
- `rx_err`  in  1  PHY receive error.
- `rx_byte`  out  8  received byte; meaningful only when `rx_valid`.
- `rx_valid`  out  1  one-cycle strobe per byte.
- `rx_sof`  out  1  qualifies the first byte of a frame.
- `rx_eof`  out  1  qualifies the last byte of a frame.
- `rx_frame_err`  out  1  valid with `rx_eof`: frame is bad.
- `rx_len`  out  LEN_W  valid with `rx_eof`: bytes delivered in this frame.

## Operation
- All outputs are registered and are 0 after reset. Reset applied mid-frame discards the frame with no `rx_eof`, then enters IDLE.
- States:
  - IDLE: `crs_dv`=0 or dibit `00` → stay. `crs_dv`=1 with dibit `01` → PREAMBLE with count=1. Dibit `10`/`11` or `rx_err` → DROP.
  - PREAMBLE: `01` → count++ (saturates at 255). `11` with count ≥ MIN_PREAMBLE_DIBITS → DATA. `11` with a short count, `00`/`10`, or `rx_err` → DROP. `crs_dv`=0 → IDLE.
  - DATA: shift dibits in LSB-first, so the byte is {d3,d2,d1,d0}. `crs_dv`=0 ends the frame and returns to IDLE.
  - DROP: ignore everything until `crs_dv`=0, then go to IDLE. No output is produced in DROP.
- DATA uses a one-byte holding register, because the end of a frame is only known when `crs_dv` falls.
  - A completed byte first enters the holding register.
  - The previous held byte is then emitted with `rx_eof`=0.
- At end of frame (`crs_dv` falls in DATA):
  - The held byte is emitted with `rx_eof`=1.
  - `rx_frame_err` = sticky `rx_err` seen in DATA, OR alignment error (dibit phase ≠ 0 when `crs_dv` falls), OR overflow.
  - A partial trailing byte is discarded.
- A frame with zero complete bytes produces no output at all.
- Overflow: when a byte would be the (MAX_FRAME_BYTES+1)th, emit the held byte with `rx_eof`=1 and `rx_frame_err`=1, then go to DROP.
- `rx_sof`=1 on the first emitted byte of a frame. A one-byte frame has `rx_sof`=`rx_eof`=1.
- `rx_len` counts emitted bytes, 1..MAX_FRAME_BYTES.

## Timing
- The 4th dibit of byte k is sampled on edge N. Byte k−1 appears on the outputs after edge N (visible in cycle N+1).
- The last byte is emitted on the cycle after the edge that samples `crs_dv`=0.
- `rx_valid` is a single-cycle pulse. Back-to-back bytes are at least 4 cycles apart.
- A new frame may start on the cycle right after end of frame. IDLE accepts `01` on the same edge that the final byte is emitted.
- `rx_err` and `crs_dv`=0 on the same edge in DATA: the frame ends with `rx_frame_err`=1.

## Structure
- Shared `mac_pkg` holds:
  - the `rx_state_t` enum (IDLE, PREAMBLE, DATA, DROP);
  - constants `PREAMBLE_DIBIT`=2'b01 and `SFD_DIBIT`=2'b11, shared with the TX MAC.
- One optional sub-module, `rmii_dibit_deser`: a 2-bit phase counter plus shift register that outputs a byte and a `byte_done` strobe. The FSM, holding register, length counter and error logic stay in `mac_rx`.

## Test plan
- 28×`01`, `11`, then bytes 0x55, 0xAA, 0x0F, then `crs_dv` drops → 3 strobes: 0x55 with sof, 0xAA, 0x0F with eof; `rx_len`=3; `rx_frame_err`=0.
- Only 4×`01` then `11` → DROP; no `rx_valid` until the next valid frame, which must then be received intact.
- `rx_err` pulsed during the 2nd of 5 bytes → all 5 bytes emitted; eof with `rx_frame_err`=1, `rx_len`=5.
- 2 full bytes plus 1 extra dibit, then `crs_dv` drops → 2 bytes; eof on the 2nd with `rx_frame_err`=1 (alignment).
- With MAX_FRAME_BYTES=4, send 6 bytes → 4 bytes emitted, eof+err on the 4th; no output for bytes 5–6.
- `rst_n`=0 during byte 3 of a frame → all outputs 0 the next cycle; no eof; the next frame is received correctly.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC definitions: the RMII receive FSM state type and line-code dibits.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rx_state_t;

    // Line-code dibits. The TX MAC transmits the same values.
    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT      = 2'b11;

endpackage

// File: rtl/mac_rx_if.sv
// RMII receive pins plus the byte stream the MAC delivers to ingress.
// Latency: none (wiring only).
// Backpressure: none; the byte stream is strobe-only and the sink must keep up.
// Ports: crs_dv/rx_data/rx_err come from the PHY; rx_byte/rx_valid/rx_sof/rx_eof/
//        rx_frame_err/rx_len go to ingress. master = MAC side, slave = PHY/sink side.
interface mac_rx_if #(
    parameter int LEN_W = 11
);
    logic             crs_dv;
    logic [1:0]       rx_data;
    logic             rx_err;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_sof;
    logic             rx_eof;
    logic             rx_frame_err;
    logic [LEN_W-1:0] rx_len;

    modport master (
        input  crs_dv, rx_data, rx_err,
        output rx_byte, rx_valid, rx_sof, rx_eof, rx_frame_err, rx_len
    );

    modport slave (
        output crs_dv, rx_data, rx_err,
        input  rx_byte, rx_valid, rx_sof, rx_eof, rx_frame_err, rx_len
    );
endinterface

// File: rtl/rmii_dibit_deser.sv
// Dibit-to-byte deserialiser: shifts RMII dibits in LSB-first and flags each completed byte.
// Latency: combinational; data_out/byte_done are valid in the cycle the 4th dibit is presented.
// Backpressure: none; shift is an enable, not a handshake.
// Ports: clk, rst_n (sync, active-low), clear (restart at phase 0), shift (accept dibit),
//        dibit in; data_out (assembled byte), byte_done (strobe), phase (dibits held so far).
module rmii_dibit_deser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       shift,
    input  logic [1:0] dibit,
    output logic [7:0] data_out,
    output logic       byte_done,
    output logic [1:0] phase
);

    logic [7:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sr    <= 8'h00;
            phase <= 2'd0;
        end else if (shift) begin
            sr    <= {dibit, sr[7:2]};
            phase <= phase + 2'd1;
        end
    end

    // The 4th dibit lands in the top bits, giving {d3,d2,d1,d0} without an extra cycle.
    assign data_out  = {dibit, sr[7:2]};
    assign byte_done = shift && (phase == 2'd3);

endmodule

// File: rtl/mac_rx.sv
// RMII receive MAC: preamble/SFD detection, byte assembly, SOF/EOF/error/length framing.
// Latency: byte k-1 is emitted the cycle after byte k completes; last byte the cycle after crs_dv falls.
// Backpressure: none; rx_valid is a one-cycle strobe at most once every 4 cycles.
// Ports: clk, rst_n (sync, active-low), bus (mac_rx_if.master: RMII inputs in, byte stream out).
module mac_rx
    import mac_pkg::*;
#(
    parameter int MAX_FRAME_BYTES     = 1518,
    parameter int MIN_PREAMBLE_DIBITS = 8,
    parameter int LEN_W               = $clog2(MAX_FRAME_BYTES + 1)
) (
    input  logic      clk,
    input  logic      rst_n,
    mac_rx_if.master  bus
);

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_FRAME_BYTES);
    localparam logic [7:0]       MIN_PRE = 8'(MIN_PREAMBLE_DIBITS);

    rx_state_t        state, state_nxt;
    logic [7:0]       pre_cnt, pre_cnt_nxt;
    // Completed bytes in the current frame; the newest one sits in 'held'.
    logic [LEN_W-1:0] rcv_cnt, rcv_cnt_nxt;
    logic             err_sticky, err_sticky_nxt;
    logic [7:0]       held, held_nxt;

    logic             emit, emit_eof, emit_err;
    logic             deser_clear, deser_shift;
    logic [7:0]       deser_data;
    logic             byte_done;
    logic [1:0]       phase;

    rmii_dibit_deser u_deser (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (deser_clear),
        .shift     (deser_shift),
        .dibit     (bus.rx_data),
        .data_out  (deser_data),
        .byte_done (byte_done),
        .phase     (phase)
    );

    always_comb begin
        state_nxt      = state;
        pre_cnt_nxt    = pre_cnt;
        rcv_cnt_nxt    = rcv_cnt;
        err_sticky_nxt = err_sticky;
        held_nxt       = held;
        emit           = 1'b0;
        emit_eof       = 1'b0;
        emit_err       = 1'b0;
        deser_clear    = (state != DATA);
        deser_shift    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.crs_dv) begin
                    if (bus.rx_err) begin
                        state_nxt = DROP;
                    end else if (bus.rx_data == PREAMBLE_DIBIT) begin
                        state_nxt   = PREAMBLE;
                        pre_cnt_nxt = 8'd1;
                    end else if (bus.rx_data != 2'b00) begin
                        state_nxt = DROP;
                    end
                end
            end

            PREAMBLE: begin
                if (!bus.crs_dv) begin
                    state_nxt = IDLE;
                end else if (bus.rx_err) begin
                    state_nxt = DROP;
                end else if (bus.rx_data == PREAMBLE_DIBIT) begin
                    if (pre_cnt != 8'hFF) begin
                        pre_cnt_nxt = pre_cnt + 8'd1;
                    end
                end else if (bus.rx_data == SFD_DIBIT && pre_cnt >= MIN_PRE) begin
                    state_nxt      = DATA;
                    rcv_cnt_nxt    = '0;
                    err_sticky_nxt = 1'b0;
                end else begin
                    state_nxt = DROP;
                end
            end

            DATA: begin
                if (!bus.crs_dv) begin
                    // End of frame: flush the held byte; a partial byte is an alignment error.
                    state_nxt = IDLE;
                    if (rcv_cnt != '0) begin
                        emit     = 1'b1;
                        emit_eof = 1'b1;
                        emit_err = err_sticky || bus.rx_err || (phase != 2'd0);
                    end
                end else begin
                    deser_shift = 1'b1;
                    if (bus.rx_err) begin
                        err_sticky_nxt = 1'b1;
                    end
                    if (byte_done) begin
                        if (rcv_cnt == MAX_CNT) begin
                            // One byte too many: close the frame on the held byte.
                            emit      = 1'b1;
                            emit_eof  = 1'b1;
                            emit_err  = 1'b1;
                            state_nxt = DROP;
                        end else begin
                            held_nxt    = deser_data;
                            rcv_cnt_nxt = rcv_cnt + LEN_W'(1);
                            emit        = (rcv_cnt != '0);
                        end
                    end
                end
            end

            DROP: begin
                if (!bus.crs_dv) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            pre_cnt          <= 8'd0;
            rcv_cnt          <= '0;
            err_sticky       <= 1'b0;
            held             <= 8'h00;
            bus.rx_byte      <= 8'h00;
            bus.rx_valid     <= 1'b0;
            bus.rx_sof       <= 1'b0;
            bus.rx_eof       <= 1'b0;
            bus.rx_frame_err <= 1'b0;
            bus.rx_len       <= '0;
        end else begin
            state            <= state_nxt;
            pre_cnt          <= pre_cnt_nxt;
            rcv_cnt          <= rcv_cnt_nxt;
            err_sticky       <= err_sticky_nxt;
            held             <= held_nxt;
            // Every emission is the held byte, whose frame index is rcv_cnt.
            bus.rx_valid     <= emit;
            bus.rx_byte      <= emit ? held : 8'h00;
            bus.rx_sof       <= emit && (rcv_cnt == LEN_W'(1));
            bus.rx_eof       <= emit_eof;
            bus.rx_frame_err <= emit_err;
            bus.rx_len       <= emit_eof ? rcv_cnt : '0;
        end
    end

endmodule

// File: tb/tb_mac_rx.sv
// Bench for mac_rx: two instances (default and 4-byte maximum) share one RMII stimulus.
// Latency: not applicable.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_mac_rx;
    import mac_pkg::*;

    localparam int MAX_A = 1518;
    localparam int LEN_A = $clog2(MAX_A + 1);
    localparam int MAX_B = 4;
    localparam int LEN_B = $clog2(MAX_B + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       crs_dv = 1'b0;
    logic [1:0] rx_data = 2'b00;
    logic       rx_err = 1'b0;

    always #10 clk = ~clk;

    mac_rx_if #(.LEN_W(LEN_A)) bus_a ();
    mac_rx_if #(.LEN_W(LEN_B)) bus_b ();

    assign bus_a.crs_dv  = crs_dv;
    assign bus_a.rx_data = rx_data;
    assign bus_a.rx_err  = rx_err;
    assign bus_b.crs_dv  = crs_dv;
    assign bus_b.rx_data = rx_data;
    assign bus_b.rx_err  = rx_err;

    mac_rx #(.MAX_FRAME_BYTES(MAX_A), .MIN_PREAMBLE_DIBITS(8), .LEN_W(LEN_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    mac_rx #(.MAX_FRAME_BYTES(MAX_B), .MIN_PREAMBLE_DIBITS(8), .LEN_W(LEN_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    typedef struct {
        logic [7:0] data;
        bit         sof;
        bit         eof;
        bit         err;
        int         len;
    } exp_t;

    typedef struct {
        int          pre;     // 01 dibits before the 11
        int          nb;      // whole payload bytes
        int          extra;   // trailing dibits after the whole bytes
        int          err_at;  // payload dibit index carrying rx_err; nb*4+extra = on the crs_dv fall
        int          gap;     // idle cycles after the frame, including the crs_dv=0 edge
        logic [63:0] dat;     // byte k = dat[8k+:8]
        int          len_a;
        bit          err_a;
        int          len_b;
        bit          err_b;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboards: each emitted byte is checked against the next expected record.
    always @(negedge clk) begin
        if (bus_a.rx_valid === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_extra_valid", bus_a.rx_valid, 0);
            end else begin
                ea = qa.pop_front();
                chk("a_byte", bus_a.rx_byte, ea.data);
                chk("a_sof", bus_a.rx_sof, ea.sof);
                chk("a_eof", bus_a.rx_eof, ea.eof);
                if (ea.eof) begin
                    chk("a_len", bus_a.rx_len, ea.len);
                    chk("a_err", bus_a.rx_frame_err, ea.err);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.rx_valid === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_extra_valid", bus_b.rx_valid, 0);
            end else begin
                eb = qb.pop_front();
                chk("b_byte", bus_b.rx_byte, eb.data);
                chk("b_sof", bus_b.rx_sof, eb.sof);
                chk("b_eof", bus_b.rx_eof, eb.eof);
                if (eb.eof) begin
                    chk("b_len", bus_b.rx_len, eb.len);
                    chk("b_err", bus_b.rx_frame_err, eb.err);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit dv, input logic [1:0] d, input bit e);
        crs_dv  = dv;
        rx_data = d;
        rx_err  = e;
        step();
    endtask

    task automatic push_frame(input vec_t v);
        for (int k = 0; k < v.len_a; k++)
            qa.push_back('{v.dat[8*k +: 8], k == 0, k == v.len_a - 1, v.err_a, v.len_a});
        for (int k = 0; k < v.len_b; k++)
            qb.push_back('{v.dat[8*k +: 8], k == 0, k == v.len_b - 1, v.err_b, v.len_b});
    endtask

    task automatic check_drained(input string tag);
        @(negedge clk);
        #1;
        chk({tag, "_a_pending"}, qa.size(), 0);
        chk({tag, "_b_pending"}, qb.size(), 0);
    endtask

    task automatic drive_frame(input vec_t v);
        int         d;
        logic [7:0] b;
        push_frame(v);
        for (int i = 0; i < v.pre; i++) put(1'b1, PREAMBLE_DIBIT, 1'b0);
        put(1'b1, SFD_DIBIT, 1'b0);
        d = 0;
        for (int k = 0; k < v.nb; k++) begin
            b = v.dat[8*k +: 8];
            for (int j = 0; j < 4; j++) begin
                put(1'b1, b[2*j +: 2], d == v.err_at);
                d++;
            end
        end
        for (int j = 0; j < v.extra; j++) begin
            put(1'b1, 2'b10, d == v.err_at);
            d++;
        end
        put(1'b0, 2'b00, d == v.err_at);
        for (int g = 1; g < v.gap; g++) put(1'b0, 2'b00, 1'b0);
        check_drained("frame");
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_a_valid"}, bus_a.rx_valid, 0);
        chk({tag, "_a_sof"}, bus_a.rx_sof, 0);
        chk({tag, "_a_eof"}, bus_a.rx_eof, 0);
        chk({tag, "_a_err"}, bus_a.rx_frame_err, 0);
        chk({tag, "_a_byte"}, bus_a.rx_byte, 0);
        chk({tag, "_a_len"}, bus_a.rx_len, 0);
        chk({tag, "_b_valid"}, bus_b.rx_valid, 0);
        chk({tag, "_b_eof"}, bus_b.rx_eof, 0);
        chk({tag, "_b_len"}, bus_b.rx_len, 0);
    endtask

    localparam int NV = 14;
    vec_t tbl[NV];

    initial begin
        logic [7:0] tb_b;

        //            pre nb  x  err_at gap dat                        lenA errA lenB errB
        tbl[0]  = '{28, 3, 0, -1, 4, 64'h0000_0000_000F_AA55,      3, 0, 3, 0};
        tbl[1]  = '{ 4, 2, 0, -1, 4, 64'h0000_0000_0000_1234,      0, 0, 0, 0};
        tbl[2]  = '{ 8, 5, 0,  5, 4, 64'h0000_0055_4433_2211,      5, 1, 4, 1};
        tbl[3]  = '{ 8, 2, 1, -1, 4, 64'h0000_0000_0000_A55A,      2, 1, 2, 1};
        tbl[4]  = '{10, 6, 0, -1, 4, 64'h0000_F0E1_D2C3_B4A5,      6, 0, 4, 1};
        tbl[5]  = '{ 7, 3, 0, -1, 4, 64'h0000_0000_0077_8899,      0, 0, 0, 0};
        tbl[6]  = '{ 8, 0, 0, -1, 4, 64'h0,                        0, 0, 0, 0};
        tbl[7]  = '{ 8, 0, 3, -1, 4, 64'h0,                        0, 0, 0, 0};
        tbl[8]  = '{12, 1, 0, -1, 1, 64'h0000_0000_0000_007E,      1, 0, 1, 0};
        tbl[9]  = '{ 8, 4, 0, -1, 4, 64'h0000_0000_DEAD_BEEF,      4, 0, 4, 0};
        tbl[10] = '{ 8, 3, 0, 12, 4, 64'h0000_0000_0001_0203,      3, 1, 3, 1};
        tbl[11] = '{300, 2, 0, -1, 4, 64'h0000_0000_0000_8001,     2, 0, 2, 0};
        tbl[12] = '{ 0, 2, 0, -1, 4, 64'h0000_0000_0000_3344,      0, 0, 0, 0};
        tbl[13] = '{ 8, 8, 0, -1, 4, 64'h0123_4567_89AB_CDEF,      8, 0, 4, 1};

        // Reset state.
        rst_n = 1'b0;
        step();
        step();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        put(1'b0, 2'b00, 1'b0);
        put(1'b0, 2'b00, 1'b0);

        // Cycle-exact timing of a two-byte frame on the default instance.
        qa.push_back('{8'h3C, 1'b1, 1'b0, 1'b0, 2});
        qa.push_back('{8'hC3, 1'b0, 1'b1, 1'b0, 2});
        qb.push_back('{8'h3C, 1'b1, 1'b0, 1'b0, 2});
        qb.push_back('{8'hC3, 1'b0, 1'b1, 1'b0, 2});
        for (int i = 0; i < 8; i++) put(1'b1, PREAMBLE_DIBIT, 1'b0);
        put(1'b1, SFD_DIBIT, 1'b0);
        tb_b = 8'h3C;
        for (int j = 0; j < 4; j++) put(1'b1, tb_b[2*j +: 2], 1'b0);
        tb_b = 8'hC3;
        for (int j = 0; j < 3; j++) put(1'b1, tb_b[2*j +: 2], 1'b0);
        chk("t_no_early_valid", bus_a.rx_valid, 0);
        put(1'b1, tb_b[7:6], 1'b0);
        chk("t_first_valid", bus_a.rx_valid, 1);
        chk("t_first_byte", bus_a.rx_byte, 8'h3C);
        chk("t_first_sof", bus_a.rx_sof, 1);
        put(1'b0, 2'b00, 1'b0);
        chk("t_last_valid", bus_a.rx_valid, 1);
        chk("t_last_byte", bus_a.rx_byte, 8'hC3);
        chk("t_last_eof", bus_a.rx_eof, 1);
        chk("t_last_len", bus_a.rx_len, 2);
        put(1'b0, 2'b00, 1'b0);
        chk("t_pulse_end", bus_a.rx_valid, 0);
        check_drained("timing");

        // Table of frames.
        for (int v = 0; v < NV; v++) drive_frame(tbl[v]);

        // Reset in the middle of byte 3: byte 1 is already out, nothing else follows.
        qa.push_back('{8'h31, 1'b1, 1'b0, 1'b0, 0});
        qb.push_back('{8'h31, 1'b1, 1'b0, 1'b0, 0});
        for (int i = 0; i < 8; i++) put(1'b1, PREAMBLE_DIBIT, 1'b0);
        put(1'b1, SFD_DIBIT, 1'b0);
        tb_b = 8'h31;
        for (int j = 0; j < 4; j++) put(1'b1, tb_b[2*j +: 2], 1'b0);
        tb_b = 8'h42;
        for (int j = 0; j < 4; j++) put(1'b1, tb_b[2*j +: 2], 1'b0);
        put(1'b1, 2'b01, 1'b0);
        rst_n = 1'b0;
        put(1'b1, 2'b10, 1'b0);
        check_outputs_zero("midrst");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) put(1'b0, 2'b00, 1'b0);
        check_drained("midrst");
        drive_frame(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
